// File: rtl/afe_rx_pkg.sv
// Shared types for the AFE receive capture path.
// Holds the capture FSM states and the FIFO entry flag layout.
package afe_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VD,
        WAIT_HD,
        SKIP,
        ACTIVE,
        DONE
    } state_t;

    // FIFO entry is {flags, data}; flags sit above the sample bits.
    typedef struct packed {
        logic sof;
        logic eol;
    } ent_flags_t;

    localparam int ENT_FLAG_W = $bits(ent_flags_t);

endpackage

// File: rtl/afe_rx_fifo.sv
// Small synchronous FIFO buffering captured pixels toward the stream output.
// A write is accepted while full when a read happens in the same cycle.
module afe_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 18
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_wr;
    logic          do_rd;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

endmodule

// File: rtl/afe_rx_capture.sv
// Captures one cropped frame from the AFE sample bus using HD/VD/DCLK
// strobes and streams it out through a small FIFO as valid/ready pixels.
import afe_rx_pkg::*;

module afe_rx_capture #(
    parameter int DATA_W     = 16,
    parameter int H_SKIP     = 24,
    parameter int H_ACTIVE   = 1600,
    parameter int V_SKIP     = 2,
    parameter int V_ACTIVE   = 1200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              afe_dclk,
    input  logic              afe_hd,
    input  logic              afe_vd,
    input  logic [DATA_W-1:0] afe_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_sof,
    output logic              m_eol,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int XW = $clog2(H_SKIP + H_ACTIVE + 1);
    localparam int YW = $clog2(V_SKIP + V_ACTIVE + 1);
    localparam int EW = DATA_W + ENT_FLAG_W;

    localparam logic [XW-1:0] X_LAST    = XW'(H_ACTIVE - 1);
    localparam logic [XW-1:0] SKIP_LAST = XW'(H_SKIP - 1);
    localparam logic [YW-1:0] Y_FIRST   = YW'(V_SKIP);
    localparam logic [YW-1:0] Y_LAST    = YW'(V_SKIP + V_ACTIVE - 1);
    localparam logic [YW-1:0] Y_END     = YW'(V_SKIP + V_ACTIVE);
    localparam state_t LINE_START = (H_SKIP == 0) ? ACTIVE : SKIP;

    state_t        state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          dclk_q, hd_q, vd_q;
    logic          dclk_rise, hd_fall, vd_fall;
    logic          vd_restart, in_frame, push, pop;
    logic          full, empty;
    ent_flags_t    wr_flags, rd_flags;
    logic [EW-1:0] wr_ent, rd_ent;

    assign dclk_rise  = afe_dclk & ~dclk_q;
    assign hd_fall    = ~afe_hd & hd_q;
    assign vd_fall    = ~afe_vd & vd_q;
    assign vd_restart = vd_fall && (state inside {WAIT_HD, SKIP, ACTIVE});
    assign in_frame   = (y >= Y_FIRST) && (y <= Y_LAST);
    assign push       = (state == ACTIVE) && dclk_rise && !hd_fall
                        && !vd_restart && in_frame;
    assign pop        = m_valid & m_ready;

    always_comb begin
        wr_flags     = '0;
        wr_flags.sof = (x == '0) && (y == Y_FIRST);
        wr_flags.eol = (x == X_LAST);
    end

    assign wr_ent   = {wr_flags, afe_data};
    assign rd_flags = rd_ent[EW-1 -: ENT_FLAG_W];

    // Outputs read as zero whenever nothing is queued.
    assign m_valid = ~empty;
    assign m_data  = empty ? '0 : rd_ent[DATA_W-1:0];
    assign m_sof   = ~empty & rd_flags.sof;
    assign m_eol   = ~empty & rd_flags.eol;

    afe_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (wr_ent),
        .rd_en   (pop),
        .rd_data (rd_ent),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dclk_q <= 1'b0;
            hd_q   <= 1'b1;
            vd_q   <= 1'b1;
        end else begin
            dclk_q <= afe_dclk;
            hd_q   <= afe_hd;
            vd_q   <= afe_vd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            x        <= '0;
            y        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
            if (vd_restart) begin
                x     <= '0;
                y     <= '0;
                state <= WAIT_HD;
            end else begin
                case (state)
                    IDLE: begin
                        if (arm) begin
                            busy     <= 1'b1;
                            overflow <= 1'b0;
                            state    <= WAIT_VD;
                        end
                    end
                    WAIT_VD: begin
                        if (vd_fall) begin
                            y     <= '0;
                            state <= WAIT_HD;
                        end
                    end
                    WAIT_HD: begin
                        if (hd_fall) begin
                            x     <= '0;
                            state <= LINE_START;
                        end
                    end
                    SKIP, ACTIVE: begin
                        // A line sync here means the line came up short.
                        if (hd_fall) begin
                            x     <= '0;
                            y     <= (y == Y_END) ? y : y + YW'(1);
                            state <= LINE_START;
                        end else if (dclk_rise && state == SKIP) begin
                            if (x == SKIP_LAST) begin
                                x     <= '0;
                                state <= ACTIVE;
                            end else begin
                                x <= x + XW'(1);
                            end
                        end else if (dclk_rise) begin
                            if (x == X_LAST) begin
                                x <= '0;
                                if (y >= Y_LAST) begin
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                    state <= DONE;
                                end else begin
                                    y     <= y + YW'(1);
                                    state <= WAIT_HD;
                                end
                            end else begin
                                x <= x + XW'(1);
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
